// File: rtl/id_decode_stage.sv
// RV32I/RV64I instruction-decode stage: combinational field/immediate decode
// captured into a main output register backed by a one-entry skid register.
module id_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [31:0]     i_in_instr,
  input  logic [PC_W-1:0] i_in_pc,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [PC_W-1:0] o_out_pc,
  output logic [6:0]      o_op,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [2:0]      o_funct3,
  output logic [6:0]      o_funct7,
  output logic [XLEN-1:0] o_imm,
  output logic [3:0]      o_itype,
  output logic            o_illegal
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam bit         RV64       = (XLEN == 64);

  typedef enum logic [3:0] {
    IT_R      = 4'd0,
    IT_OPIMM  = 4'd1,
    IT_LOAD   = 4'd2,
    IT_STORE  = 4'd3,
    IT_BRANCH = 4'd4,
    IT_JAL    = 4'd5,
    IT_JALR   = 4'd6,
    IT_LUI    = 4'd7,
    IT_AUIPC  = 4'd8,
    IT_SYSTEM = 4'd9,
    IT_ILL    = 4'd15
  } itype_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    itype_e          itype;
    logic            illegal;
  } beat_t;

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_j;
  logic [XLEN-1:0] w_imm_u;
  logic            w_up_zero;
  logic            w_up_sra;
  logic            w_legal;
  itype_e          w_cls;
  beat_t           w_dec;
  logic            w_accept;
  logic            w_pop;

  beat_t           r_main;
  beat_t           r_skid;
  logic            r_main_valid;
  logic            r_skid_valid;

  assign w_op = i_in_instr[6:0];
  assign w_f3 = i_in_instr[14:12];
  assign w_f7 = i_in_instr[31:25];

  assign w_imm_i = XLEN'($signed(i_in_instr[31:20]));
  assign w_imm_s = XLEN'($signed({i_in_instr[31:25], i_in_instr[11:7]}));
  assign w_imm_b = XLEN'($signed({i_in_instr[31], i_in_instr[7], i_in_instr[30:25],
                                  i_in_instr[11:8], 1'b0}));
  assign w_imm_j = XLEN'($signed({i_in_instr[31], i_in_instr[19:12], i_in_instr[20],
                                  i_in_instr[30:21], 1'b0}));
  assign w_imm_u = XLEN'($signed({i_in_instr[31:12], 12'b0}));

  // On RV64 instr[25] is shamt[5], so only instr[31:26] qualify the shift.
  assign w_up_zero = RV64 ? (i_in_instr[31:26] == 6'b000000)
                          : (i_in_instr[31:25] == 7'b0000000);
  assign w_up_sra  = RV64 ? (i_in_instr[31:26] == 6'b010000)
                          : (i_in_instr[31:25] == 7'b0100000);

  // NOTE: every signal driven in an always_comb gets a default on entry, so no
  // path through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    w_cls   = IT_ILL;
    w_legal = 1'b0;
    case (w_op)
      OPC_R: begin
        w_cls   = IT_R;
        w_legal = (w_f7 == 7'b0000000) ||
                  ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
      end
      OPC_OPIMM: begin
        w_cls   = IT_OPIMM;
        w_legal = !((w_f3 == 3'b001) && !w_up_zero) &&
                  !((w_f3 == 3'b101) && !(w_up_zero || w_up_sra));
      end
      OPC_LOAD:   begin w_cls = IT_LOAD;   w_legal = 1'b1; end
      OPC_STORE:  begin w_cls = IT_STORE;  w_legal = 1'b1; end
      OPC_BRANCH: begin w_cls = IT_BRANCH; w_legal = 1'b1; end
      OPC_JAL:    begin w_cls = IT_JAL;    w_legal = 1'b1; end
      OPC_JALR:   begin w_cls = IT_JALR;   w_legal = (w_f3 == 3'b000); end
      OPC_LUI:    begin w_cls = IT_LUI;    w_legal = 1'b1; end
      OPC_AUIPC:  begin w_cls = IT_AUIPC;  w_legal = 1'b1; end
      OPC_SYSTEM: begin w_cls = IT_SYSTEM; w_legal = 1'b1; end
      default:    begin w_cls = IT_ILL;    w_legal = 1'b0; end
    endcase
  end

  // Fields a format does not use stay zero; an illegal beat keeps only op and pc.
  always_comb begin
    w_dec         = '0;
    w_dec.pc      = i_in_pc;
    w_dec.op      = w_op;
    w_dec.itype   = IT_ILL;
    w_dec.illegal = 1'b1;
    if (w_legal) begin
      w_dec.itype   = w_cls;
      w_dec.illegal = 1'b0;
      case (w_cls)
        IT_R: begin
          w_dec.rd     = i_in_instr[11:7];
          w_dec.rs1    = i_in_instr[19:15];
          w_dec.rs2    = i_in_instr[24:20];
          w_dec.funct3 = w_f3;
          w_dec.funct7 = w_f7;
        end
        IT_OPIMM: begin
          w_dec.rd     = i_in_instr[11:7];
          w_dec.rs1    = i_in_instr[19:15];
          w_dec.funct3 = w_f3;
          w_dec.imm    = w_imm_i;
          if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) w_dec.funct7 = w_f7;
        end
        IT_LOAD, IT_JALR, IT_SYSTEM: begin
          w_dec.rd     = i_in_instr[11:7];
          w_dec.rs1    = i_in_instr[19:15];
          w_dec.funct3 = w_f3;
          w_dec.imm    = w_imm_i;
        end
        IT_STORE: begin
          w_dec.rs1    = i_in_instr[19:15];
          w_dec.rs2    = i_in_instr[24:20];
          w_dec.funct3 = w_f3;
          w_dec.imm    = w_imm_s;
        end
        IT_BRANCH: begin
          w_dec.rs1    = i_in_instr[19:15];
          w_dec.rs2    = i_in_instr[24:20];
          w_dec.funct3 = w_f3;
          w_dec.imm    = w_imm_b;
        end
        IT_JAL: begin
          w_dec.rd  = i_in_instr[11:7];
          w_dec.imm = w_imm_j;
        end
        IT_LUI, IT_AUIPC: begin
          w_dec.rd  = i_in_instr[11:7];
          w_dec.imm = w_imm_u;
        end
        default: ;
      endcase
    end
  end

  assign o_in_ready = !r_skid_valid;
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_pop      = r_main_valid && i_out_ready;

  // NOTE: state registers use non-blocking assignments so every register samples
  // pre-edge values; the skid->main move relies on reading the old r_skid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      // NOTE: the data registers are reset too, not just their valid bits,
      // because the outputs must read all-zero straight out of reset.
      r_main       <= '0;
      r_skid       <= '0;
    end else if (i_flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_pop || !r_main_valid) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= w_accept;
        if (w_accept) r_skid <= w_dec;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) r_main <= w_dec;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign o_out_valid = r_main_valid;
  assign o_out_pc    = r_main.pc;
  assign o_op        = r_main.op;
  assign o_rd        = r_main.rd;
  assign o_rs1       = r_main.rs1;
  assign o_rs2       = r_main.rs2;
  assign o_funct3    = r_main.funct3;
  assign o_funct7    = r_main.funct7;
  assign o_imm       = r_main.imm;
  assign o_itype     = r_main.itype;
  assign o_illegal   = r_main.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: an XLEN=32 and an XLEN=64 instance,
// hand-decoded expected beats queued at acceptance and popped by monitors.
module tb_id_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [3:0]  it;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;

  logic        in_valid32, in_ready32, out_valid32, out_ready32, illegal32;
  logic [31:0] in_instr32, in_pc32, out_pc32, imm32;
  logic [6:0]  op32, f7_32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [2:0]  f3_32;
  logic [3:0]  it32;

  logic        in_valid64, in_ready64, out_valid64, out_ready64, illegal64;
  logic [31:0] in_instr64, in_pc64, out_pc64;
  logic [63:0] imm64;
  logic [6:0]  op64, f7_64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  f3_64;
  logic [3:0]  it64;

  id_decode_stage #(.XLEN(32), .PC_W(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(in_valid32), .o_in_ready(in_ready32),
    .i_in_instr(in_instr32), .i_in_pc(in_pc32),
    .o_out_valid(out_valid32), .i_out_ready(out_ready32),
    .o_out_pc(out_pc32), .o_op(op32), .o_rd(rd32), .o_rs1(rs1_32), .o_rs2(rs2_32),
    .o_funct3(f3_32), .o_funct7(f7_32), .o_imm(imm32), .o_itype(it32),
    .o_illegal(illegal32)
  );

  id_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(in_valid64), .o_in_ready(in_ready64),
    .i_in_instr(in_instr64), .i_in_pc(in_pc64),
    .o_out_valid(out_valid64), .i_out_ready(out_ready64),
    .o_out_pc(out_pc64), .o_op(op64), .o_rd(rd64), .o_rs1(rs1_64), .o_rs2(rs2_64),
    .o_funct3(f3_64), .o_funct7(f7_64), .o_imm(imm64), .o_itype(it64),
    .o_illegal(illegal64)
  );

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q32[$];
  exp_t q64[$];
  exp_t act32, exp32, act64, exp64;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [63:0] imm, input logic [3:0] it,
                              input logic ill);
    exp_t e;
    e.pc = '0; e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
    e.f3 = f3; e.f7 = f7; e.imm = imm; e.it = it; e.ill = ill;
    return e;
  endfunction

  always @(negedge clk) begin
    if (out_valid32 && out_ready32) begin
      act32.pc = out_pc32; act32.op = op32; act32.rd = rd32; act32.rs1 = rs1_32;
      act32.rs2 = rs2_32; act32.f3 = f3_32; act32.f7 = f7_32; act32.imm = {32'b0, imm32};
      act32.it = it32; act32.ill = illegal32;
      n_vec++;
      if (q32.size() == 0) begin
        n_err++;
        $display("FAIL beat32 unexpected: got pc=%h", out_pc32);
      end else begin
        exp32 = q32.pop_front();
        if (act32 !== exp32) begin
          n_err++;
          $display("FAIL beat32 pc=%h: got %h want %h", exp32.pc, act32, exp32);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid64 && out_ready64) begin
      act64.pc = out_pc64; act64.op = op64; act64.rd = rd64; act64.rs1 = rs1_64;
      act64.rs2 = rs2_64; act64.f3 = f3_64; act64.f7 = f7_64; act64.imm = imm64;
      act64.it = it64; act64.ill = illegal64;
      n_vec++;
      if (q64.size() == 0) begin
        n_err++;
        $display("FAIL beat64 unexpected: got pc=%h", out_pc64);
      end else begin
        exp64 = q64.pop_front();
        if (act64 !== exp64) begin
          n_err++;
          $display("FAIL beat64 pc=%h: got %h want %h", exp64.pc, act64, exp64);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one beat for one cycle; acc is whether the stage must take it.
  task automatic send(input bit w64, input logic [31:0] instr, input logic [31:0] pc,
                      input bit acc, input exp_t e);
    if (w64) begin
      in_valid64 = 1'b1; in_instr64 = instr; in_pc64 = pc;
    end else begin
      in_valid32 = 1'b1; in_instr32 = instr; in_pc32 = pc;
    end
    @(negedge clk);
    if (w64) check("in_ready64", {63'b0, in_ready64}, {63'b0, acc});
    else     check("in_ready32", {63'b0, in_ready32}, {63'b0, acc});
    if (acc) begin
      e.pc = pc;
      if (w64) q64.push_back(e);
      else     q32.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid32 = 1'b0;
    in_valid64 = 1'b0;
  endtask

  task automatic check_zero32(input string tag);
    check({tag, "_out_valid"}, {63'b0, out_valid32}, 64'd0);
    check({tag, "_in_ready"},  {63'b0, in_ready32},  64'd1);
    check({tag, "_out_pc"},    {32'b0, out_pc32},    64'd0);
    check({tag, "_op"},        {57'b0, op32},        64'd0);
    check({tag, "_rd"},        {59'b0, rd32},        64'd0);
    check({tag, "_rs1"},       {59'b0, rs1_32},      64'd0);
    check({tag, "_rs2"},       {59'b0, rs2_32},      64'd0);
    check({tag, "_funct3"},    {61'b0, f3_32},       64'd0);
    check({tag, "_funct7"},    {57'b0, f7_32},       64'd0);
    check({tag, "_imm"},       {32'b0, imm32},       64'd0);
    check({tag, "_itype"},     {60'b0, it32},        64'd0);
    check({tag, "_illegal"},   {63'b0, illegal32},   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_valid32 = 1'b0; in_instr32 = '0; in_pc32 = '0; out_ready32 = 1'b1;
    in_valid64 = 1'b0; in_instr64 = '0; in_pc64 = '0; out_ready64 = 1'b1;
    tick(2);
    check_zero32("reset");
    rst = 1'b0;
    tick(1);

    // Back-to-back stream: each beat must be on the outputs right after its edge.
    send(0, 32'hFFF00093, 32'h100, 1, mk(7'h13, 1, 0, 0, 0, 0, 64'hFFFFFFFF, 1, 0));
    check("lat_addi", {31'b0, out_valid32, out_pc32}, {31'b0, 1'b1, 32'h100});
    send(0, 32'h12345137, 32'h104, 1, mk(7'h37, 2, 0, 0, 0, 0, 64'h12345000, 7, 0));
    check("lat_lui", {31'b0, out_valid32, out_pc32}, {31'b0, 1'b1, 32'h104});
    send(0, 32'h00000000, 32'h108, 1, mk(7'h00, 0, 0, 0, 0, 0, 64'h0, 15, 1));
    send(0, 32'h02208033, 32'h10C, 1, mk(7'h33, 0, 0, 0, 0, 0, 64'h0, 15, 1));
    send(0, 32'h002081B3, 32'h110, 1, mk(7'h33, 3, 1, 2, 0, 7'h00, 64'h0, 0, 0));
    send(0, 32'h407302B3, 32'h114, 1, mk(7'h33, 5, 6, 7, 0, 7'h20, 64'h0, 0, 0));
    send(0, 32'hFE20AC23, 32'h118, 1, mk(7'h23, 0, 1, 2, 2, 0, 64'hFFFFFFF8, 3, 0));
    send(0, 32'h0101A203, 32'h11C, 1, mk(7'h03, 4, 3, 0, 2, 0, 64'h10, 2, 0));
    send(0, 32'h001000EF, 32'h120, 1, mk(7'h6F, 1, 0, 0, 0, 0, 64'h800, 5, 0));
    send(0, 32'h00008067, 32'h124, 1, mk(7'h67, 0, 1, 0, 0, 0, 64'h0, 6, 0));
    send(0, 32'h00009067, 32'h128, 1, mk(7'h67, 0, 0, 0, 0, 0, 64'h0, 15, 1));
    send(0, 32'hFFFFF297, 32'h12C, 1, mk(7'h17, 5, 0, 0, 0, 0, 64'hFFFFF000, 8, 0));
    send(0, 32'h40315093, 32'h130, 1, mk(7'h13, 1, 2, 0, 5, 7'h20, 64'h403, 1, 0));
    send(0, 32'h02111093, 32'h134, 1, mk(7'h13, 0, 0, 0, 0, 0, 64'h0, 15, 1));
    send(0, 32'h00000073, 32'h138, 1, mk(7'h73, 0, 0, 0, 0, 0, 64'h0, 9, 0));
    send(0, 32'hFE000EE3, 32'h13C, 1, mk(7'h63, 0, 0, 0, 0, 0, 64'hFFFFFFFC, 4, 0));
    tick(2);

    // RV64: 64-bit sign extension and the wider shamt field.
    send(1, 32'hFE000EE3, 32'h400, 1, mk(7'h63, 0, 0, 0, 0, 0, 64'hFFFFFFFFFFFFFFFC, 4, 0));
    send(1, 32'hFFF00093, 32'h404, 1, mk(7'h13, 1, 0, 0, 0, 0, 64'hFFFFFFFFFFFFFFFF, 1, 0));
    send(1, 32'h02111093, 32'h408, 1, mk(7'h13, 1, 2, 0, 1, 7'h01, 64'h21, 1, 0));
    send(1, 32'h40315093, 32'h40C, 1, mk(7'h13, 1, 2, 0, 5, 7'h20, 64'h403, 1, 0));
    send(1, 32'hFFFFF297, 32'h410, 1, mk(7'h17, 5, 0, 0, 0, 0, 64'hFFFFFFFFFFFFF000, 8, 0));
    tick(2);

    // Stall: three beats offered, two taken, outputs frozen, then drained in order.
    out_ready32 = 1'b0;
    send(0, 32'h002081B3, 32'h200, 1, mk(7'h33, 3, 1, 2, 0, 7'h00, 64'h0, 0, 0));
    check("stall_p_valid", {63'b0, out_valid32}, 64'd1);
    send(0, 32'h407302B3, 32'h204, 1, mk(7'h33, 5, 6, 7, 0, 7'h20, 64'h0, 0, 0));
    check("stall_hold1_pc", {32'b0, out_pc32}, 64'h200);
    send(0, 32'h0101A203, 32'h208, 0, mk(7'h03, 4, 3, 0, 2, 0, 64'h10, 2, 0));
    check("stall_hold2_pc", {32'b0, out_pc32}, 64'h200);
    check("stall_in_ready", {63'b0, in_ready32}, 64'd0);
    out_ready32 = 1'b1;
    tick(1);
    check("drain_in_ready", {63'b0, in_ready32}, 64'd1);
    check("drain_q", {31'b0, out_valid32, out_pc32}, {31'b0, 1'b1, 32'h204});
    tick(1);
    check("drain_empty", {63'b0, out_valid32}, 64'd0);
    tick(1);

    // Flush with both entries full; the beat offered alongside must vanish.
    out_ready32 = 1'b0;
    send(0, 32'h002081B3, 32'h300, 1, mk(7'h33, 3, 1, 2, 0, 7'h00, 64'h0, 0, 0));
    send(0, 32'h407302B3, 32'h304, 1, mk(7'h33, 5, 6, 7, 0, 7'h20, 64'h0, 0, 0));
    in_valid32 = 1'b1; in_instr32 = 32'h0101A203; in_pc32 = 32'h308; flush = 1'b1;
    tick(1);
    in_valid32 = 1'b0; flush = 1'b0;
    q32.delete();
    check("flush_full_valid", {63'b0, out_valid32}, 64'd0);
    check("flush_full_ready", {63'b0, in_ready32}, 64'd1);
    out_ready32 = 1'b1;
    tick(3);

    // Flush with only main full: in_ready is high, yet the beat is still dropped.
    out_ready32 = 1'b0;
    send(0, 32'h002081B3, 32'h310, 1, mk(7'h33, 3, 1, 2, 0, 7'h00, 64'h0, 0, 0));
    in_valid32 = 1'b1; in_instr32 = 32'h0101A203; in_pc32 = 32'h314; flush = 1'b1;
    tick(1);
    in_valid32 = 1'b0; flush = 1'b0;
    q32.delete();
    check("flush_main_valid", {63'b0, out_valid32}, 64'd0);
    check("flush_main_ready", {63'b0, in_ready32}, 64'd1);
    out_ready32 = 1'b1;
    tick(3);

    // Reset and flush together with both entries full.
    out_ready32 = 1'b0;
    send(0, 32'hFE20AC23, 32'h320, 1, mk(7'h23, 0, 1, 2, 2, 0, 64'hFFFFFFF8, 3, 0));
    send(0, 32'hFFFFF297, 32'h324, 1, mk(7'h17, 5, 0, 0, 0, 0, 64'hFFFFF000, 8, 0));
    in_valid32 = 1'b1; in_instr32 = 32'h12345137; in_pc32 = 32'h328;
    rst = 1'b1; flush = 1'b1;
    tick(1);
    check_zero32("rstflush");
    rst = 1'b0; flush = 1'b0; in_valid32 = 1'b0;
    q32.delete();
    out_ready32 = 1'b1;
    tick(2);

    send(0, 32'hFFF00093, 32'h330, 1, mk(7'h13, 1, 0, 0, 0, 0, 64'hFFFFFFFF, 1, 0));
    tick(4);
    check("q32_drained", 64'(q32.size()), 64'd0);
    check("q64_drained", 64'(q64.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_decode_stage.md
# id_decode_stage

Registered, parametrised RV32I/RV64I instruction-decode stage with a valid/ready handshake. It sits between fetch and register-read. It splits each instruction word into fields and produces a fully sign-extended, type-correct immediate of XLEN bits. It classifies the instruction, flags illegal encodings, and absorbs one cycle of downstream back-pressure in a 2-entry skid buffer without losing throughput.

## Interface
- XLEN, 32: datapath width. Legal values are 32 or 64. Sets immediate width and shamt legality checks.
- PC_W, 32: width of the PC carried alongside the instruction.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  drop all buffered instructions. Synchronous.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_pc  out  PC_W  PC of the decoded instruction.
- op  out  7  opcode, instr[6:0].
- rd, rs1, rs2  out  5 each  register indices. Zero when the format does not use the field.
- funct3  out  3  instr[14:12]. Zero for JAL/LUI/AUIPC.
- funct7  out  7  instr[31:25] for R-type and shift-immediate. Zero otherwise.
- imm  out  XLEN  sign-extended immediate.
- itype  out  4  class code:
  - 0 R, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC, 9 SYSTEM, 15 illegal.
- illegal  out  1  illegal encoding.

## Operation
- Opcodes:
  - R=0110011, OP-IMM=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011.
  - JAL=1101111, JALR=1100111, LUI=0110111, AUIPC=0010111, SYSTEM=1110011.
- Immediate assembly. All values are sign-extended from instr[31] to XLEN.
  - I (OP-IMM, LOAD, JALR, SYSTEM): instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - R: 0.
- Illegal when any of the following holds:
  - opcode is not listed above;
  - R-type funct7 is not 0000000 or 0100000 (0100000 is legal only with funct3 000 or 101);
  - OP-IMM funct3=001 with non-zero upper bits;
  - OP-IMM funct3=101 with upper bits other than 0/0100000 pattern. Upper bits are instr[31:25] when XLEN=32 and instr[31:26] when XLEN=64;
  - JALR funct3≠000.
- An illegal beat still propagates:
  - illegal=1, itype=15, op and out_pc preserved;
  - all other field outputs and imm are 0.
- Decode is combinational on in_instr. Results are captured into the buffer on acceptance.
- Buffer: a main output register plus a skid register.
  - Accept when in_valid && in_ready.
  - If the main register is empty, or is being consumed this cycle (out_valid && out_ready), the beat loads the main register.
  - Otherwise the beat loads the skid register.
  - When the main register is consumed and the skid is full, the skid moves to main. A simultaneous input beat then goes to the skid.
- in_ready = !skid_full, registered. Accepted beats are never dropped except by flush or rst.
- Ordering is strictly FIFO.

## Timing
- Latency: an input accepted at edge N is on the outputs with out_valid=1 after edge N. This is 1 cycle.
- Throughput: 1 beat/cycle while out_ready=1.
- Back-pressure:
  - out_valid && !out_ready holds every output stable.
  - One further beat may be accepted into the skid. in_ready falls at the next edge.
  - in_ready rises at the edge where the skid drains into main.
- Reset (rst=1 at an edge):
  - out_valid=0, skid empty, in_ready=1, illegal=0, itype=0;
  - all field outputs, imm and out_pc are 0.
  - Reset mid-stall discards both entries. An input beat in the reset cycle is dropped.
- Flush (flush=1 at an edge):
  - both entries are invalidated; out_valid=0 and in_ready=1 after the edge;
  - data outputs may hold stale values;
  - an input beat presented in the flush cycle is dropped, even if in_ready=1.
- rst has priority over flush.

## Test plan
- Stream with out_ready=1: ADDI x1,x0,-1 (0xFFF00093) then LUI x2,0x12345 (0x12345137).
  - Consecutive cycles show itype=1, rd=1, imm=0xFFFFFFFF; then itype=7, rd=2, imm=0x12345000.
  - 1-cycle latency, no bubbles.
- XLEN=64, BEQ with offset -4 (0xFE000EE3).
  - itype=4, rs1=0, rs2=0, imm=0xFFFFFFFFFFFFFFFC, rd=0.
- Illegal words: 0x00000000, then R-type ADD with funct7=0000001 (0x02208033).
  - Both give illegal=1, itype=15, imm=0, out_pc preserved.
- Stall: hold out_ready=0 for 3 cycles while driving 3 beats.
  - Exactly 2 are accepted; in_ready=0 from the second acceptance.
  - On release, beats emerge in order on consecutive cycles, then in_ready=1.
- Flush and reset with both entries full.
  - Flush gives out_valid=0, in_ready=1 next cycle, and the beat presented in the flush cycle is never output.
  - Repeat with rst=1 and flush=1 together: all outputs are 0 after the edge.
